// File: rtl/fp_pkg.sv
// Shared single-precision FPU types and field constants.
// Used by the adder result queue and the classifier, and by any other FPU stage
// that needs to decode the exponent or mantissa of an IEEE-754 single.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Per-result status carried with every queued entry.
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  // Sticky accrued exception flags exposed to the CSR path.
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
  } fflags_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies an IEEE-754 single as NaN, infinity or zero (sign ignored).
// Latency: purely combinational, no state.
// Backpressure: none; output follows input in the same cycle.
// Ports: value (32-bit operand) -> is_nan, is_inf, is_zero (mutually exclusive).
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] value,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = value[30:23];
  assign man_f       = value[22:0];
  // The sign never affects the class; +0/-0 and +Inf/-Inf fold together.
  assign unused_sign = value[31];

  assign is_nan  = (exp_f == EXP_MAX) && (man_f != '0);
  assign is_inf  = (exp_f == EXP_MAX) && (man_f == '0);
  assign is_zero = (value[30:0] == 31'd0);

endmodule

// File: rtl/fp_add_result_queue.sv
// Queues adder results with per-entry class/exception flags and keeps sticky fflags.
// Latency: a pushed entry is visible on out_* exactly one cycle later; no fall-through.
// Backpressure: in_ready = !full from registered state only; a pop does not free a slot the same cycle.
// Ports: in_* push side (valid/ready), out_* pop side (valid/ready), count occupancy,
//        fflags sticky {NV,OF,UF} with fflags_clr; clk rising edge, rst synchronous active-high.
module fp_add_result_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [4:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2:0]               fflags,
  input  logic                     fflags_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      result;
    fp_flags_t        flags;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  fflags_t          sticky;
  fflags_t          sticky_nxt;
  logic             push;
  logic             pop;
  logic             cls_nan;
  logic             cls_inf;
  logic             cls_zero;

  fp_classify u_classify (
    .value   (in_result),
    .is_nan  (cls_nan),
    .is_inf  (cls_inf),
    .is_zero (cls_zero)
  );

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry                 = '0;
    new_entry.result          = in_result;
    new_entry.flags.is_nan    = cls_nan;
    new_entry.flags.is_inf    = cls_inf;
    new_entry.flags.is_zero   = cls_zero;
    new_entry.flags.overflow  = in_overflow;
    new_entry.flags.underflow = in_underflow;
    new_entry.tag             = in_tag;
  end

  // Clear takes effect before the pushed entry's bits are merged, so a
  // simultaneous clear+push leaves exactly the new entry's flags.
  always_comb begin
    sticky_nxt = fflags_clr ? '0 : sticky;
    if (push) begin
      sticky_nxt.nv = sticky_nxt.nv | cls_nan;
      sticky_nxt.of = sticky_nxt.of | in_overflow;
      sticky_nxt.uf = sticky_nxt.uf | in_underflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      sticky <= '0;
      // Slot 0 is the head after reset, so clearing it zeroes out_*.
      mem[0] <= '0;
    end else begin
      sticky <= sticky_nxt;
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign out_result = mem[rd_ptr].result;
  assign out_flags  = mem[rd_ptr].flags;
  assign out_tag    = mem[rd_ptr].tag;
  assign count      = cnt;
  assign fflags     = sticky;

endmodule

// File: tb/tb_fp_add_result_queue.sv
// Scoreboard bench for fp_add_result_queue: directed scenarios followed by random traffic.
// A reference model at the clock edge tracks the expected queue contents and sticky flags;
// a monitor on the falling edge compares every visible DUT output against it.
module tb_fp_add_result_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_result;
  logic                   in_overflow;
  logic                   in_underflow;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_result;
  logic [4:0]             out_flags;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] count;
  logic [2:0]             fflags;
  logic                   fflags_clr;

  always #5 clk = ~clk;

  fp_add_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .count        (count),
    .fflags       (fflags),
    .fflags_clr   (fflags_clr)
  );

  typedef struct {
    logic [31:0]      result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] m_fflags = 3'b000;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Class bits {nan, inf, zero} from the IEEE-754 field definitions.
  function automatic logic [2:0] ref_class(input logic [31:0] r);
    int unsigned e;
    int unsigned m;
    e = (r >> 23) & 32'hFF;
    m = r & 32'h007F_FFFF;
    if (e == 255 && m != 0)             return 3'b100;
    if (e == 255)                       return 3'b010;
    if ((r & 32'h7FFF_FFFF) == 0)       return 3'b001;
    return 3'b000;
  endfunction

  // Reference model: a bounded queue of expected entries and a sticky flag word.
  always @(posedge clk) begin
    exp_t e;
    bit   do_push;
    bit   do_pop;
    if (rst) begin
      sb.delete();
      m_fflags = 3'b000;
    end else begin
      do_pop  = out_ready && (sb.size() > 0);
      do_push = in_valid && (sb.size() < DEPTH);
      if (fflags_clr) m_fflags = 3'b000;
      e.result = in_result;
      e.flags  = {ref_class(in_result), in_overflow, in_underflow};
      e.tag    = in_tag;
      if (do_push) m_fflags = m_fflags | {e.flags[4], in_overflow, in_underflow};
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
  end

  // Monitor: compare registered DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(count), 32'(sb.size()));
      check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      check("fflags", 32'(fflags), 32'(m_fflags));
      if (out_valid && sb.size() > 0) begin
        check("head_result", out_result, sb[0].result);
        check("head_flags", 32'(out_flags), 32'(sb[0].flags));
        check("head_tag", 32'(out_tag), 32'(sb[0].tag));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic u,
                       input logic [TAG_W-1:0] t, input logic rd, input logic clr);
    in_valid     = v;
    in_result    = r;
    in_overflow  = o;
    in_underflow = u;
    in_tag       = t;
    out_ready    = rd;
    fflags_clr   = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rd);
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0, rd, 1'b0);
  endtask

  logic [31:0] pats [8];

  initial begin
    pats[0] = 32'h7FC0_0000; pats[1] = 32'h7F80_0000; pats[2] = 32'hFF80_0000;
    pats[3] = 32'h0000_0000; pats[4] = 32'h8000_0000; pats[5] = 32'h7F80_0001;
    pats[6] = 32'h3F80_0000; pats[7] = 32'h0000_0001;

    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_overflow = 1'b0; in_underflow = 1'b0;
    in_tag = '0; out_ready = 1'b0; fflags_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state, head slot cleared.
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_fflags", 32'(fflags), 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", 32'(out_flags), 0);
    check("rst_out_tag", 32'(out_tag), 0);

    // Two pushes, then a pop exposing the NaN.
    drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    check("p1_valid", 32'(out_valid), 1);
    check("p1_result", out_result, 32'h3F80_0000);
    check("p1_tag", 32'(out_tag), 1);
    drive(1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    check("p2_count", 32'(count), 2);
    check("p2_fflags", 32'(fflags), 32'b100);
    idle(1'b1);
    check("pop_result", out_result, 32'h7FC0_0000);
    check("pop_is_nan", 32'(out_flags[4]), 1);
    idle(1'b1);
    check("drain_empty", 32'(out_valid), 0);

    // Fill to full; a push alongside a pop while full is refused.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 4'(i), 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_count", 32'(count), 4);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
    check("full_push_refused", 32'(count), 3);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Streaming push+pop across pointer wrap.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 4'(i), 1'b1, 1'b0);
      check("stream_count_le1", 32'(count <= 1), 1);
      check("stream_head", out_result, 32'(i));
    end
    idle(1'b1);

    // Sticky flags: clear alone, then overflow, then clear+underflow push.
    idle(1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("clr_alone", 32'(fflags), 0);
    drive(1'b1, 32'h7F80_0000, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    check("of_push", 32'(fflags), 32'b010);
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
    check("clr_with_push", 32'(fflags), 32'b001);
    idle(1'b1);
    check("zero_uf_flags", 32'(out_flags), 32'b00101);
    idle(1'b1);

    // Reset mid-operation with a push presented during reset.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h7FC0_0000, 1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 3);
    check("pre_rst_fflags", 32'(fflags), 32'b111);
    rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    rst = 1'b0;
    check("post_rst_count", 32'(count), 0);
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_fflags", 32'(fflags), 0);
    drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    check("post_rst_push_valid", 32'(out_valid), 1);
    check("post_rst_push_result", out_result, 32'h4000_0000);

    // Random traffic; the monitor checks every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 1) == 0) ? pats[$urandom_range(0, 7)] : $urandom;
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 7) == 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
